// File: rtl/alu_sequencer_if.sv
// Bundle for the sequencer: instruction-memory port, ALU operand/result port, output port and halt status.
// The master side belongs to the sequencer, the slave side to the memory/ALU environment.
interface alu_sequencer_if;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_zf;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;

  modport master (
    output imem_addr, imem_req, alu_a, alu_b, alu_sel, out_data, out_valid, halted,
    input  imem_ack, imem_data, alu_out, alu_zf
  );

  modport slave (
    input  imem_addr, imem_req, alu_a, alu_b, alu_sel, out_data, out_valid, halted,
    output imem_ack, imem_data, alu_out, alu_zf
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit core: 4x8 register file, external ALU.
// Define SEQ_OUT_PORT_EN to implement the OUT instruction; otherwise it decodes as a NOP.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic            zf_q, zf_d;
  logic            req_q, req_d;
  logic            taken;

  logic [1:0] cls, sub, rd, rs;
  assign cls = ir_q[7:6];
  assign sub = ir_q[5:4];
  assign rd  = ir_q[3:2];
  assign rs  = ir_q[1:0];

  always_comb begin
    case (sub)
      2'b00:   taken = 1'b1;
      2'b01:   taken = zf_q;
      2'b10:   taken = ~zf_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    zf_d    = zf_q;
    case (state_q)
      S_FETCH: begin
        if (req_q && bus.imem_ack) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          2'b00:        state_d = S_EXEC;
          2'b01, 2'b10: state_d = S_IMM;
          default:      state_d = (sub == 2'b11) ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC: begin
        regs_d[rd] = bus.alu_out;
        zf_d       = bus.alu_zf;
        state_d    = S_FETCH;
      end
      S_IMM: begin
        if (req_q && bus.imem_ack) begin
          if (cls == 2'b01) begin
            regs_d[rd] = bus.imem_data;
            pc_d       = pc_q + 8'd1;
          end else begin
            pc_d = taken ? bus.imem_data : pc_q + 8'd1;
          end
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Request is registered: it rises on the edge that enters FETCH/IMM and falls after the ack.
    req_d = (state_d == S_FETCH) || (state_d == S_IMM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      regs_q  <= '0;
      zf_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      zf_q    <= zf_d;
      req_q   <= req_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_req  = req_q;
  assign bus.alu_a     = regs_q[rd];
  assign bus.alu_b     = regs_q[rs];
  assign bus.alu_sel   = sub;
  assign bus.halted    = (state_q == S_HALT);

`ifdef SEQ_OUT_PORT_EN
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       out_fire;

  assign out_fire = (state_q == S_DECODE) && (cls == 2'b11) && (sub == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_fire;
      if (out_fire) out_data_q <= regs_q[rs];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`else
  assign bus.out_valid = 1'b0;
  assign bus.out_data  = 8'h00;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random programs run on alu_sequencer against an instruction-level reference model,
// with a behavioural memory (configurable/random wait states) and ALU.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] alu_f(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_out = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
  assign bus.alu_zf  = (bus.alu_out == 8'h00);

  logic [7:0] mem [256];
  int  wait_fixed = 0;
  bit  wait_rnd = 0;

  // observed logs
  int          acc_addr[$];
  int          acc_t[$];
  int          exec_log[$];
  int          out_log[$];
  int          out_t[$];
  bit          halt_seen;
  int          halt_t;
  // expected logs from the reference model
  int          e_acc[$];
  int          e_t[$];
  int          e_exec[$];
  int          e_out[$];
  int          e_out_t[$];
  int          e_halt_t;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory responder and monitor, all sampled mid-cycle on the falling edge
  int  cyc, cnt, cur_wait, exec_at;
  bit  expect_imm, prev_wait;
  logic [7:0] prev_addr, byte_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; cnt = 0; exec_at = -1; expect_imm = 0; prev_wait = 0;
      cur_wait = wait_rnd ? $urandom_range(0, 3) : wait_fixed;
      bus.imem_ack = 1'b0;
      bus.imem_data = 8'h00;
    end else begin
      cyc++;
      if (bus.imem_req) bus.imem_ack = (cnt >= cur_wait);
      else bus.imem_ack = wait_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.imem_data = mem[bus.imem_addr];
      if (exec_at == cyc) exec_log.push_back({14'd0, bus.alu_sel, bus.alu_a, bus.alu_b});
      if (bus.out_valid) begin
        out_log.push_back(int'(bus.out_data));
        out_t.push_back(cyc);
      end
      if (bus.halted && !halt_seen) begin
        halt_seen = 1;
        halt_t = cyc;
      end
      if (bus.imem_req && prev_wait) chk("addr_stable", int'(bus.imem_addr), int'(prev_addr));
      if (bus.imem_req && bus.imem_ack) begin
        acc_addr.push_back(int'(bus.imem_addr));
        acc_t.push_back(cyc);
        byte_v = bus.imem_data;
        if (expect_imm) expect_imm = 0;
        else if (byte_v[7:6] == 2'b01 || byte_v[7:6] == 2'b10) expect_imm = 1;
        else if (byte_v[7:6] == 2'b00) exec_at = cyc + 2;
        cnt = 0;
        cur_wait = wait_rnd ? $urandom_range(0, 3) : wait_fixed;
        prev_wait = 0;
      end else if (bus.imem_req) begin
        cnt++;
        prev_wait = 1;
        prev_addr = bus.imem_addr;
      end else begin
        prev_wait = 0;
      end
    end
  end

  // Instruction-level reference: executes the program byte by byte and predicts fetches,
  // ALU operands, output values and (for a fixed wait w) the cycle of every event.
  task automatic iss(input int w);
    logic [7:0] r[4];
    logic [7:0] pc, ins, imm, a, b, res;
    logic zf;
    int t, st;
    bit done, tk;
    e_acc.delete(); e_t.delete(); e_exec.delete(); e_out.delete(); e_out_t.delete();
    e_halt_t = -1;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    zf = 0; pc = 8'h00; t = 0; done = 0; st = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      ins = mem[pc];
      e_acc.push_back(int'(pc)); e_t.push_back(t);
      pc = pc + 8'd1;
      case (ins[7:6])
        2'b00: begin
          a = r[ins[3:2]]; b = r[ins[1:0]];
          res = alu_f(ins[5:4], a, b);
          e_exec.push_back({14'd0, ins[5:4], a, b});
          r[ins[3:2]] = res;
          zf = (res == 8'h00);
          st = t + 3;
        end
        2'b01, 2'b10: begin
          e_acc.push_back(int'(pc)); e_t.push_back(t + 2 + w);
          imm = mem[pc];
          tk = (ins[5:4] == 2'b00) || (ins[5:4] == 2'b01 && zf) || (ins[5:4] == 2'b10 && !zf);
          if (ins[7:6] == 2'b01) begin
            r[ins[3:2]] = imm;
            pc = pc + 8'd1;
          end else pc = tk ? imm : pc + 8'd1;
          st = t + 3 + w;
        end
        default: begin
          if (ins[5:4] == 2'b11) begin
            e_halt_t = t + 2;
            done = 1;
          end
`ifdef SEQ_OUT_PORT_EN
          else if (ins[5:4] == 2'b01) begin
            e_out.push_back(int'(r[ins[1:0]]));
            e_out_t.push_back(t + 2);
          end
`endif
          st = t + 2;
        end
      endcase
      t = st + w;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_t.delete(); exec_log.delete(); out_log.delete(); out_t.delete();
    halt_seen = 0; halt_t = 0;
  endtask

  task automatic run_prog(input string name, input int w, input bit rnd, input bit chk_t);
    int nmin;
    wait_fixed = w; wait_rnd = rnd;
    rst_n = 1'b0;
    @(posedge clk); #2;
    clear_logs();
    @(posedge clk); #2;
    rst_n = 1'b1;
    iss(w);
    for (int i = 0; i < 3000 && !halt_seen; i++) @(negedge clk);
    chk({name, ":halt_seen"}, int'(halt_seen), 1);
    chk({name, ":n_fetch"}, acc_addr.size(), e_acc.size());
    nmin = (acc_addr.size() < e_acc.size()) ? acc_addr.size() : e_acc.size();
    for (int i = 0; i < nmin; i++) begin
      chk({name, ":fetch_addr"}, acc_addr[i], e_acc[i]);
      if (chk_t) chk({name, ":fetch_cycle"}, acc_t[i] - acc_t[0], e_t[i]);
    end
    chk({name, ":n_exec"}, exec_log.size(), e_exec.size());
    nmin = (exec_log.size() < e_exec.size()) ? exec_log.size() : e_exec.size();
    for (int i = 0; i < nmin; i++) chk({name, ":alu_sel_a_b"}, exec_log[i], e_exec[i]);
    chk({name, ":n_out"}, out_log.size(), e_out.size());
    nmin = (out_log.size() < e_out.size()) ? out_log.size() : e_out.size();
    for (int i = 0; i < nmin; i++) begin
      chk({name, ":out_data"}, out_log[i], e_out[i]);
      if (chk_t && acc_t.size() > 0) chk({name, ":out_cycle"}, out_t[i] - acc_t[0], e_out_t[i]);
    end
    if (chk_t && halt_seen && acc_t.size() > 0) chk({name, ":halt_cycle"}, halt_t - acc_t[0], e_halt_t);
    repeat (4) @(negedge clk);
    chk({name, ":req_after_halt"}, int'(bus.imem_req), 0);
    chk({name, ":halted_held"}, int'(bus.halted), 1);
    chk({name, ":no_fetch_after_halt"}, acc_addr.size(), e_acc.size());
  endtask

  task automatic gen_random();
    int n;
    int ad[14];
    logic [7:0] op[13];
    logic [7:0] imm[13];
    logic [1:0] cls, sub, rd, rs;
    clear_mem();
    n = $urandom_range(4, 12);
    for (int i = 0; i < n; i++) begin
      cls = 2'($urandom_range(0, 3));
      sub = 2'($urandom_range(0, 3));
      rd  = 2'($urandom_range(0, 3));
      rs  = 2'($urandom_range(0, 3));
      if (cls == 2'b11 && sub == 2'b11) sub = 2'b01;
      op[i]  = {cls, sub, rd, rs};
      imm[i] = 8'($urandom);
    end
    ad[0] = 0;
    for (int i = 0; i < n; i++) ad[i+1] = ad[i] + ((op[i][7:6] == 2'b01 || op[i][7:6] == 2'b10) ? 2 : 1);
    for (int i = 0; i < n; i++) begin
      mem[8'(ad[i])] = op[i];
      if (op[i][7:6] == 2'b01) mem[8'(ad[i] + 1)] = imm[i];
      if (op[i][7:6] == 2'b10) mem[8'(ad[$urandom_range(i + 1, n)])] = mem[8'(ad[$urandom_range(i + 1, n)])];
      if (op[i][7:6] == 2'b10) mem[8'(ad[i] + 1)] = 8'(ad[$urandom_range(i + 1, n)]);
    end
    mem[8'(ad[n])] = 8'hFF;
  endtask

  initial begin
    rst_n = 1'b0;
    wait_fixed = 0; wait_rnd = 0;
    clear_mem();
    clear_logs();
    repeat (2) @(negedge clk);

    // reset state
    chk("rst:imem_req", int'(bus.imem_req), 0);
    chk("rst:imem_addr", int'(bus.imem_addr), 0);
    chk("rst:out_valid", int'(bus.out_valid), 0);
    chk("rst:out_data", int'(bus.out_data), 0);
    chk("rst:halted", int'(bus.halted), 0);
    chk("rst:alu_a", int'(bus.alu_a), 0);
    chk("rst:alu_b", int'(bus.alu_b), 0);
    chk("rst:alu_sel", int'(bus.alu_sel), 0);

    // LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h05; mem[2] = 8'h44; mem[3] = 8'h03;
    mem[4] = 8'h01; mem[5] = 8'hD0; mem[6] = 8'hFF;
    run_prog("basic_w0", 0, 0, 1);
`ifdef SEQ_OUT_PORT_EN
    chk("basic_w0:out_eq_08", (out_log.size() > 0) ? out_log[0] : -1, 8);
`endif
    run_prog("basic_w3", 3, 0, 1);

    // LDI r2,0x11; SUB r2,r2; JZ 0x40 -> taken
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h11; mem[2] = 8'h1A; mem[3] = 8'h90; mem[4] = 8'h40;
    mem[8'h40] = 8'hFF;
    run_prog("jz_taken", 0, 0, 1);
    chk("jz_taken:last_fetch", (acc_addr.size() > 0) ? acc_addr[acc_addr.size()-1] : -1, 8'h40);
    mem[3] = 8'hA0;
    run_prog("jnz_fallthru", 0, 0, 1);
    chk("jnz_fallthru:last_fetch", (acc_addr.size() > 0) ? acc_addr[acc_addr.size()-1] : -1, 8'h05);

    // pc wrap through 0xFE/0xFF back to 0x00
    clear_mem();
    mem[0] = 8'h90; mem[1] = 8'h10; mem[2] = 8'h30; mem[3] = 8'h80; mem[4] = 8'hFE;
    mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'hC0; mem[8'h10] = 8'hFF;
    run_prog("pc_wrap", 1, 0, 1);

    // AND r3,r0 -> 0, zf=1; ADD r3,r3 shows r3==0; LDI r3,0x7F; JZ 0x20 taken
    clear_mem();
    mem[0] = 8'h4C; mem[1] = 8'hF0; mem[2] = 8'h40; mem[3] = 8'h0F; mem[4] = 8'h2C;
    mem[5] = 8'h0F; mem[6] = 8'h4C; mem[7] = 8'h7F; mem[8] = 8'h90; mem[9] = 8'h20;
    mem[8'h20] = 8'hFF;
    run_prog("and_zf", 0, 0, 1);

    // reset asserted while the IMM request is pending
    clear_mem();
    mem[0] = 8'h44; mem[1] = 8'h55; mem[2] = 8'h01; mem[3] = 8'hFF;
    wait_fixed = 5; wait_rnd = 0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    clear_logs();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && acc_addr.size() == 0; i++) @(negedge clk);
    chk("mid_imm:first_acc", acc_addr.size(), 1);
    @(negedge clk); @(negedge clk);
    #1;
    chk("mid_imm:req_pending", int'(bus.imem_req), 1);
    chk("mid_imm:addr_pending", int'(bus.imem_addr), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_imm:req_dropped", int'(bus.imem_req), 0);
    chk("mid_imm:addr_reset", int'(bus.imem_addr), 0);
    chk("mid_imm:alu_sel_reset", int'(bus.alu_sel), 0);
    run_prog("after_mid_reset", 0, 0, 1);

    // random programs, random waits and spurious acks
    for (int k = 0; k < 8; k++) begin
      gen_random();
      run_prog("rand_rw", 0, 1, 0);
    end
    for (int k = 0; k < 6; k++) begin
      gen_random();
      run_prog("rand_fw", k % 3, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
